// File: rtl/xform_pkg.sv
// Shared word type and reference byte transform for the shared-datapath arbiter.
package xform_pkg;

    localparam int XFORM_W = 16;

    typedef logic [15:0] xword_t;

    function automatic xword_t xform_f(input xword_t in);
        logic [7:0] t0;
        logic [7:0] t1;
        logic [7:0] t2;
        logic [7:0] t3;
        // Only the low byte of in+1 reaches the result, so the upper input byte drops out.
        t0 = 8'(in + 16'd1);
        t1 = t0 | in[7:0];
        t2 = t1 + t0;
        t3 = t2 & t1;
        return {t3, t2};
    endfunction

endpackage

// File: rtl/xform_pipe.sv
// Two-stage byte-transform pipeline carrying an id sideband; 2-cycle latency.
// Each stage reloads when empty or draining, so a full pipe stalls only while dst_rdy is low.
module xform_pipe
    import xform_pkg::*;
#(
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            src_vld,
    output logic            src_rdy,
    input  xword_t          src_dat,
    input  logic [ID_W-1:0] src_id,
    output logic            dst_vld,
    input  logic            dst_rdy,
    output xword_t          dst_dat,
    output logic [ID_W-1:0] dst_id
);

    logic            s1_vld;
    logic [7:0]      s1_t0;
    logic [7:0]      s1_in;
    logic [ID_W-1:0] s1_id;
    logic            s2_rdy;
    logic [7:0]      t1;
    logic [7:0]      t2;
    logic [7:0]      t3;

    assign s2_rdy  = !dst_vld || dst_rdy;
    assign src_rdy = !s1_vld || s2_rdy;

    always_comb begin
        t1 = s1_t0 | s1_in;
        t2 = t1 + s1_t0;
        t3 = t2 & t1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_t0   <= '0;
            s1_in   <= '0;
            s1_id   <= '0;
            dst_vld <= 1'b0;
            dst_dat <= '0;
            dst_id  <= '0;
        end else begin
            if (src_rdy) begin
                s1_vld <= src_vld;
            end
            if (src_vld && src_rdy) begin
                s1_t0 <= 8'(src_dat + 16'd1);
                s1_in <= src_dat[7:0];
                s1_id <= src_id;
            end
            if (s2_rdy) begin
                dst_vld <= s1_vld;
            end
            if (s1_vld && s2_rdy) begin
                dst_dat <= {t3, t2};
                dst_id  <= s1_id;
            end
        end
    end

endmodule

// File: rtl/xform_arbiter.sv
// Round-robin arbiter sharing one xform_pipe between N_REQ requesters; request to response is 2 cycles.
// A stalled grant is locked until accepted; all req_ready drop while the pipe is full and rsp_ready is low.
module xform_arbiter
    import xform_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0][15:0]  req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [15:0]             rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic [15:0]             done_cnt
);

    logic [ID_W-1:0] rr_ptr;
    logic            lock_vld;
    logic [ID_W-1:0] lock_id;
    logic            scan_vld;
    logic [ID_W-1:0] scan_id;
    logic [ID_W:0]   idx_ext;
    logic [ID_W-1:0] idx;
    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    logic            pipe_rdy;
    logic            accept;
    xword_t          sel_word;

    // Scan downward in offset so the requester closest to rr_ptr is written last and wins.
    always_comb begin
        scan_vld = 1'b0;
        scan_id  = '0;
        idx_ext  = '0;
        idx      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx_ext = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (idx_ext >= (ID_W+1)'(N_REQ)) begin
                idx_ext = idx_ext - (ID_W+1)'(N_REQ);
            end
            idx = idx_ext[ID_W-1:0];
            if (req_valid[idx]) begin
                scan_vld = 1'b1;
                scan_id  = idx;
            end
        end
    end

    always_comb begin
        grant_vld = scan_vld;
        grant_id  = scan_id;
        if (lock_vld && req_valid[lock_id]) begin
            grant_vld = 1'b1;
            grant_id  = lock_id;
        end
    end

    assign accept   = grant_vld && pipe_rdy;
    assign sel_word = req_data[grant_id];

    always_comb begin
        req_ready = '0;
        if (accept && !rst) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_id  <= '0;
        end else begin
            lock_vld <= grant_vld && !pipe_rdy;
            lock_id  <= grant_id;
            if (accept) begin
                rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (rsp_valid && rsp_ready) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end

    xform_pipe #(
        .ID_W (ID_W)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .src_vld (grant_vld),
        .src_rdy (pipe_rdy),
        .src_dat (sel_word),
        .src_id  (grant_id),
        .dst_vld (rsp_valid),
        .dst_rdy (rsp_ready),
        .dst_dat (rsp_data),
        .dst_id  (rsp_id)
    );

endmodule

// File: tb/tb_xform_arbiter.sv
// Directed vector table plus hand-written sequences for xform_arbiter, with an in-order response scoreboard.
module tb_xform_arbiter;
    import xform_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0][15:0]  req_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [15:0]         rsp_data;
    logic [IW-1:0]       rsp_id;
    logic [15:0]         done_cnt;

    xform_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: every accepted word must come back once, in order, with its id and transform.
    typedef struct { logic [IW-1:0] id; logic [15:0] din; } acc_t;
    acc_t        exp_q[$];
    logic [15:0] mdl_cnt = '0;
    int          rsp_total = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mdl_cnt   = '0;
            rsp_total = 0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    acc_t e;
                    e = exp_q.pop_front();
                    check("sb_rsp_id", 32'(rsp_id), 32'(e.id));
                    check("sb_rsp_data", 32'(rsp_data), 32'(xform_f(e.din)));
                end
                check("sb_done_cnt", 32'(done_cnt), 32'(mdl_cnt));
                mdl_cnt   = mdl_cnt + 16'd1;
                rsp_total = rsp_total + 1;
            end
            for (int g = 0; g < N; g++) begin
                if (req_valid[g] && req_ready[g]) begin
                    acc_t a;
                    a.id  = IW'(g);
                    a.din = req_data[g];
                    exp_q.push_back(a);
                end
            end
        end
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    typedef struct { logic [IW-1:0] id; logic [15:0] din; logic [15:0] dout; } vec_t;
    vec_t tbl[5];

    initial begin
        int          t;
        int          acc_cyc;
        int          acc;
        int          guard;
        logic [N-1:0] am;
        logic [15:0] hold_d;
        logic [IW-1:0] hold_i;

        tbl[0] = '{id: 2'd0, din: 16'h1234, dout: 16'h206A};
        tbl[1] = '{id: 2'd1, din: 16'h0000, dout: 16'h0002};
        tbl[2] = '{id: 2'd2, din: 16'h00FF, dout: 16'hFFFF};
        tbl[3] = '{id: 2'd3, din: 16'hFFFF, dout: 16'hFFFF};
        tbl[4] = '{id: 2'd0, din: 16'hAB00, dout: 16'h0002};

        // Reset state, with every requester valid to show ready stays low.
        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        rst       = 1'b0;

        // Single-request vectors: value, id, latency and counter.
        for (int i = 0; i < 5; i++) begin
            req_data[tbl[i].id] = tbl[i].din;
            req_valid = N'(1) << tbl[i].id;
            #1;
            t = 0;
            while (!req_ready[tbl[i].id] && t < 8) begin
                tick();
                #1;
                t++;
            end
            check($sformatf("vec%0d_accept", i), 32'(req_ready[tbl[i].id]), 32'd1);
            acc_cyc = cyc;
            tick();
            req_valid = '0;
            t = 0;
            while (!rsp_valid && t < 8) begin
                tick();
                t++;
            end
            check($sformatf("vec%0d_latency", i), 32'(cyc - acc_cyc), 32'd2);
            check($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(tbl[i].dout));
            check($sformatf("vec%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].id));
            tick();
            check($sformatf("vec%0d_done_cnt", i), 32'(done_cnt), 32'(i + 1));
        end

        // Round robin with all requesters valid and rsp_ready high.
        do_reset();
        req_data[0] = 16'h1234;
        req_data[1] = 16'h0000;
        req_data[2] = 16'h00FF;
        req_data[3] = 16'hAB00;
        req_valid   = '1;
        for (int k = 0; k < 12; k++) begin
            if (k >= 2) begin
                check($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
                check($sformatf("rr%0d_rsp_id", k), 32'(rsp_id), 32'((k - 2) % 4));
            end
            #1;
            check($sformatf("rr%0d_grant", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Backpressure: pipe empty, rr_ptr back at 0, five cycles of rsp_ready low.
        rsp_ready = 1'b0;
        req_valid = '1;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (|(req_valid & req_ready)) acc++;
            tick();
        end
        check("bp_accepts", 32'(acc), 32'd2);
        hold_d = rsp_data;
        hold_i = rsp_id;
        check("bp_rsp_data", 32'(rsp_data), 32'h206A);
        check("bp_rsp_id", 32'(rsp_id), 32'd0);
        #1;
        check("bp_req_ready", 32'(req_ready), 32'd0);
        tick();
        check("bp_hold_valid", 32'(rsp_valid), 32'd1);
        check("bp_hold_data", 32'(rsp_data), 32'(hold_d));
        check("bp_hold_id", 32'(rsp_id), 32'(hold_i));
        rsp_ready = 1'b1;
        repeat (4) tick();
        req_valid = '0;
        repeat (4) tick();
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset with both stages full.
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (3) tick();
        check("mid_full", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_done_cnt", 32'(done_cnt), 32'd0);
        check("mid_req_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_first_grant", 32'(req_ready), 32'b0001);
        tick();
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (4) tick();
        check("mid_one_rsp", 32'(done_cnt), 32'd1);

        // Random traffic then full-rate stream to exactly 65536 responses.
        do_reset();
        acc = 0;
        am  = '0;
        for (int c = 0; c < 1000; c++) begin
            for (int g = 0; g < N; g++) begin
                if (!req_valid[g] || am[g]) begin
                    req_valid[g] = ($urandom_range(0, 3) != 0);
                    req_data[g]  = 16'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            check("rnd_ready_no_valid", 32'(req_ready & ~req_valid), 32'd0);
            am  = req_valid & req_ready;
            acc = acc + $countones(am);
            tick();
        end
        rsp_ready = 1'b1;
        guard = 0;
        while (acc < 65536 && guard < 80000) begin
            for (int g = 0; g < N; g++) begin
                if (!req_valid[g] || am[g]) begin
                    req_valid[g] = 1'b1;
                    req_data[g]  = 16'($urandom);
                end
            end
            #1;
            am  = req_valid & req_ready;
            acc = acc + $countones(am);
            tick();
            guard++;
        end
        req_valid = '0;
        repeat (4) tick();
        check("wrap_accepts", 32'(acc), 32'd65536);
        check("wrap_rsp_total", 32'(rsp_total), 32'd65536);
        check("wrap_done_cnt", 32'(done_cnt), 32'h0000);
        check("wrap_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/xform_arbiter.md
# xform_arbiter

Shares one pipelined instance of the 16-bit byte-transform datapath between `N_REQ` independent requesters. Each requester has a valid/ready request channel. The block arbitrates round-robin and pushes the winning word through a 2-stage pipeline. Results return on a single valid/ready response channel tagged with the requester index. It sits between the requesting engines and the shared transform resource, and also keeps a wrapping completion counter.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default `$clog2(N_REQ)`: width of the response tag.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_ready`  out  `N_REQ`  per-requester accept; at most one bit high per cycle.
- `req_data`  in  `N_REQ`x16  per-requester input word.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_data`  out  16  transformed word.
- `rsp_id`  out  `ID_W`  index of the requester that produced `rsp_data`.
- `done_cnt`  out  16  count of completed responses; wraps at 0xFFFF -> 0x0000.

## Operation
- Datapath function, all sums modulo field width:
  - t0 = in + 1 (16 b)
  - t1 = t0[7:0] | in[7:0]
  - t2 = t1 + t0[7:0] (8 b, carry dropped)
  - t3 = t2 & t1
  - out = {t3, t2}
  - `in[15:8]` does not affect the result.
- Arbitration:
  - Round-robin pointer `rr_ptr` names the highest-priority requester.
  - The grant goes to the first requester with `req_valid` set, scanning from `rr_ptr` upward with wrap.
  - On an accepted transfer, `rr_ptr` becomes grant+1 mod `N_REQ`.
  - With no transfer, `rr_ptr` holds.
- `req_ready[g]` = granted(g) AND S1 can accept. No requester gets ready without its own valid.
- Pipeline:
  - S1 registers t0[7:0], in[7:0] and id.
  - S2 registers {t3, t2} and id, and drives `rsp_*`.
  - Each stage has its own valid bit.
  - A stage loads when it is empty or its contents move downstream in the same cycle.
  - S2 drains when `rsp_valid && rsp_ready`.
- Stall: with `rsp_ready` low and both stages full, all `req_ready` are 0. Held data and ids stay stable.
- `done_cnt` increments on each `rsp_valid && rsp_ready`.
- Reset, async assert:
  - `rr_ptr`=0, stage valids=0, `done_cnt`=0.
  - `rsp_valid`=0 and `req_ready`=0 during reset.
  - `rsp_data`/`rsp_id` read 0 after reset.
  - Reset mid-operation discards in-flight words. No response is emitted for them.

## Timing
- Latency: a request accepted in cycle N produces `rsp_valid` in cycle N+2, given `rsp_ready` held high.
- Throughput: 1 word/cycle sustained under continuous valid and ready.
- `rsp_valid` high with `rsp_ready` low: `rsp_data`/`rsp_id` hold until the handshake.
- Handshake contract:
  - Requesters must not drop `req_valid` or change `req_data` until `req_ready`.
  - The arbiter never revokes a grant while that requester's `req_valid` is high and S1 is stalled. The grant stays fixed until accepted.
- Simultaneous events: when S2 drains and S1 advances in the same cycle as a new accept, all three moves occur with no bubble.
- `done_cnt` update is visible the cycle after the handshake.

## Structure
- Package `xform_pkg`:
  - `localparam XFORM_W = 16`.
  - `typedef logic [15:0] xword_t`.
  - Function `xform_f(xword_t) -> xword_t`, the golden model shared by RTL and bench.
- Sub-module `xform_pipe`: 2-stage datapath with valid/ready and id sideband.
- Top level holds the round-robin arbiter, `rr_ptr` and `done_cnt`.

## Test plan
- Single request: requester 0, `req_data`=0x1234, `rsp_ready`=1.
  - Expect `rsp_data`=0x206A, `rsp_id`=0, exactly 2 cycles after accept.
  - Expect `done_cnt`=1.
- Boundary values:
  - 0x0000 -> 0x0002.
  - 0x00FF -> 0xFFFF.
  - 0xFFFF -> 0xFFFF.
  - 0xAB00 -> 0x0002, showing the upper byte is ignored.
- All 4 requesters valid continuously with `rsp_ready`=1:
  - Expect grants in order 0,1,2,3,0,… with one accept per cycle.
  - Expect `rsp_id` to follow the same sequence delayed by 2 cycles.
- Backpressure:
  - Hold `rsp_ready`=0 for 5 cycles with requesters active.
  - Expect exactly 2 words accepted, then `req_ready`=0 and `rsp_data` stable.
  - On release, expect in-order delivery with no loss or duplication.
- Reset mid-flight: assert `rst` with both stages full.
  - Expect `rsp_valid`=0 immediately and `done_cnt`=0.
  - After deassert, the first grant goes to requester 0.
- Counter wrap: preload by issuing 65536 responses.
  - Expect `done_cnt` to return to 0x0000.
  - Randomised traffic checked against `xform_f` throughout.
